// File: rtl/store_buffer_if.sv
// Store-buffer bus: MEM-side store/load requests and the data-memory write port.
// The store buffer uses the slave modport; the MEM stage / memory side uses master.
interface store_buffer_if #(
  parameter int AW = 32
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_funct3;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_funct3;
  logic          ld_hit;
  logic [31:0]   ld_fwd_data;
  logic          ld_stall;
  logic          dm_ready;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [2:0]    dm_funct3;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, ld_funct3, dm_ready,
    input  st_ready, ld_hit, ld_fwd_data, ld_stall, dm_write, dm_addr, dm_wdata, dm_funct3, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, ld_funct3, dm_ready,
    output st_ready, ld_hit, ld_fwd_data, ld_stall, dm_write, dm_addr, dm_wdata, dm_funct3, empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue between MEM and data memory; drains one store per cycle.
// Macro STB_FWD_EN enables exact-match load forwarding; otherwise any overlap stalls the load.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [2:0]       ent_f3   [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             empty, st_rdy, st_ok, ld_ok, push, drain;

  function automatic logic [2:0] acc_size(input logic [1:0] f);
    case (f)
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
  endfunction

`ifdef STB_FWD_EN
  function automatic logic [31:0] ld_extend(input logic [31:0] d, input logic [2:0] f);
    case (f[1:0])
      2'b00:   ld_extend = f[2] ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   ld_extend = f[2] ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: ld_extend = d;
    endcase
  endfunction
`endif

  assign empty  = (count == '0);
  assign st_rdy = (count != FULL);
  assign st_ok  = (sb.st_funct3 == 3'b000) || (sb.st_funct3 == 3'b001) || (sb.st_funct3 == 3'b010);
  assign ld_ok  = (sb.ld_funct3 == 3'b000) || (sb.ld_funct3 == 3'b001) || (sb.ld_funct3 == 3'b010) ||
                  (sb.ld_funct3 == 3'b100) || (sb.ld_funct3 == 3'b101);
  // Unsupported store widths still complete the handshake but are dropped
  assign push   = sb.st_valid && st_rdy && st_ok;
  assign drain  = !empty && sb.dm_ready;

  assign sb.st_ready = st_rdy;
  assign sb.empty    = empty;
  assign sb.dm_write = drain;
  assign sb.dm_addr   = empty ? '0 : ent_addr[rd_ptr];
  assign sb.dm_wdata  = empty ? '0 : ent_data[rd_ptr];
  assign sb.dm_funct3 = empty ? '0 : ent_f3[rd_ptr];

  logic [PW-1:0] idx;
  logic [AW:0]   l_lo, l_hi, e_lo, e_hi;
  logic [2:0]    l_sz, e_sz;
  logic          live, hit_c, stall_c;
  logic [31:0]   fwd_c;

  always_comb begin
    hit_c   = 1'b0;
    stall_c = 1'b0;
    fwd_c   = '0;
    idx     = '0;
    live    = 1'b0;
    e_sz    = '0;
    e_lo    = '0;
    e_hi    = '0;
    l_sz    = acc_size(sb.ld_funct3[1:0]);
    l_lo    = {1'b0, sb.ld_addr};
    l_hi    = l_lo + (AW+1)'(l_sz);
    if (sb.ld_valid && ld_ok) begin
      // Walk oldest slot to youngest so the youngest overlapping entry has the last word
      for (int k = DEPTH-1; k >= 0; k--) begin
        idx  = wr_ptr - PW'(k+1);
        e_sz = acc_size(ent_f3[idx][1:0]);
        e_lo = {1'b0, ent_addr[idx]};
        e_hi = e_lo + (AW+1)'(e_sz);
`ifdef STB_FWD_EN
        live = ent_vld[idx] && !(drain && (idx == rd_ptr));
`else
        live = ent_vld[idx];
`endif
        if (live && (e_lo < l_hi) && (l_lo < e_hi)) begin
`ifdef STB_FWD_EN
          if ((ent_addr[idx] == sb.ld_addr) && (e_sz >= l_sz)) begin
            hit_c   = 1'b1;
            stall_c = 1'b0;
            fwd_c   = ld_extend(ent_data[idx], sb.ld_funct3);
          end else begin
            hit_c   = 1'b0;
            stall_c = 1'b1;
            fwd_c   = '0;
          end
`else
          stall_c = 1'b1;
`endif
        end
      end
    end
  end

  assign sb.ld_hit      = hit_c;
  assign sb.ld_stall    = stall_c;
  assign sb.ld_fwd_data = fwd_c;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= sb.st_addr;
      ent_data[wr_ptr] <= sb.st_data;
      ent_f3[wr_ptr]   <= sb.st_funct3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (drain) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus hand-written corner sequences.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
`ifdef STB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  localparam int NV = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   writes;

  store_buffer_if #(.AW(AW)) bus();
  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .sb(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic sv; logic [31:0] sa; logic [31:0] sd; logic [2:0] sf;
    logic lv; logic [31:0] la; logic [2:0] lf; logic dr;
    logic rdy; logic emp; logic dw; logic [31:0] da; logic [31:0] dd; logic [2:0] df;
    logic hit; logic [31:0] fwd; logic stl; logic ovl;
  } vec_t;

  vec_t tv [NV];

  function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic [2:0] sf,
                              logic lv, logic [31:0] la, logic [2:0] lf, logic dr,
                              logic rdy, logic emp, logic dw, logic [31:0] da, logic [31:0] dd,
                              logic [2:0] df, logic hit, logic [31:0] fwd, logic stl, logic ovl);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.sf = sf; v.lv = lv; v.la = la; v.lf = lf; v.dr = dr;
    v.rdy = rdy; v.emp = emp; v.dw = dw; v.da = da; v.dd = dd; v.df = df;
    v.hit = hit; v.fwd = fwd; v.stl = stl; v.ovl = ovl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bus.st_valid = v; bus.st_addr = a; bus.st_data = d; bus.st_funct3 = f;
  endtask

  task automatic set_ld(input logic v, input logic [31:0] a, input logic [2:0] f);
    bus.ld_valid = v; bus.ld_addr = a; bus.ld_funct3 = f;
  endtask

  initial begin
    // sv, sa, sd, sf, lv, la, lf, dr | rdy, emp, dw, da, dd, df, hit, fwd, stl, ovl
    tv[0]  = mk(Y,32'h100,32'hDEADBEEF,3'd2, N,Z,3'd0, Y, Y,Y,N,Z,Z,3'd0, N,Z,N,N);
    tv[1]  = mk(N,Z,Z,3'd0, N,Z,3'd0, Y, Y,N,Y,32'h100,32'hDEADBEEF,3'd2, N,Z,N,N);
    tv[2]  = mk(N,Z,Z,3'd0, N,Z,3'd0, Y, Y,Y,N,Z,Z,3'd0, N,Z,N,N);
    tv[3]  = mk(Y,32'h200,32'h8081FF7F,3'd2, N,Z,3'd0, N, Y,Y,N,Z,Z,3'd0, N,Z,N,N);
    tv[4]  = mk(N,Z,Z,3'd0, Y,32'h200,3'd0, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, Y,32'h0000007F,N,Y);
    tv[5]  = mk(N,Z,Z,3'd0, Y,32'h200,3'd1, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, Y,32'hFFFFFF7F,N,Y);
    tv[6]  = mk(N,Z,Z,3'd0, Y,32'h200,3'd5, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, Y,32'h0000FF7F,N,Y);
    tv[7]  = mk(N,Z,Z,3'd0, Y,32'h201,3'd4, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, N,Z,Y,Y);
    tv[8]  = mk(N,Z,Z,3'd0, Y,32'h204,3'd2, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, N,Z,N,N);
    tv[9]  = mk(N,Z,Z,3'd0, Y,32'h1FC,3'd2, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, N,Z,N,N);
    tv[10] = mk(N,Z,Z,3'd0, Y,32'h200,3'd3, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, N,Z,N,N);
    tv[11] = mk(N,Z,Z,3'd0, N,32'h200,3'd2, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, N,Z,N,N);
    tv[12] = mk(Y,32'h500,32'h55,3'd3, N,Z,3'd0, N, Y,N,N,32'h200,32'h8081FF7F,3'd2, N,Z,N,N);
    tv[13] = mk(N,Z,Z,3'd0, Y,32'h200,3'd2, Y, Y,N,Y,32'h200,32'h8081FF7F,3'd2, N,Z,N,Y);
    tv[14] = mk(N,Z,Z,3'd0, N,Z,3'd0, Y, Y,Y,N,Z,Z,3'd0, N,Z,N,N);
    tv[15] = mk(Y,32'h400,32'h1,3'd2, N,Z,3'd0, N, Y,Y,N,Z,Z,3'd0, N,Z,N,N);
    tv[16] = mk(Y,32'h400,32'h2,3'd2, N,Z,3'd0, N, Y,N,N,32'h400,32'h1,3'd2, N,Z,N,N);
    tv[17] = mk(N,Z,Z,3'd0, Y,32'h400,3'd2, N, Y,N,N,32'h400,32'h1,3'd2, Y,32'h2,N,Y);
    tv[18] = mk(Y,32'h402,32'hABCD,3'd1, Y,32'h400,3'd2, N, Y,N,N,32'h400,32'h1,3'd2, Y,32'h2,N,Y);
    tv[19] = mk(N,Z,Z,3'd0, Y,32'h400,3'd2, N, Y,N,N,32'h400,32'h1,3'd2, N,Z,Y,Y);
    tv[20] = mk(N,Z,Z,3'd0, Y,32'h402,3'd1, N, Y,N,N,32'h400,32'h1,3'd2, Y,32'hFFFFABCD,N,Y);
    tv[21] = mk(N,Z,Z,3'd0, Y,32'h400,3'd5, N, Y,N,N,32'h400,32'h1,3'd2, Y,32'h2,N,Y);
    tv[22] = mk(N,Z,Z,3'd0, N,Z,3'd0, Y, Y,N,Y,32'h400,32'h1,3'd2, N,Z,N,N);
    tv[23] = mk(N,Z,Z,3'd0, N,Z,3'd0, Y, Y,N,Y,32'h400,32'h2,3'd2, N,Z,N,N);
    tv[24] = mk(N,Z,Z,3'd0, N,Z,3'd0, Y, Y,N,Y,32'h402,32'hABCD,3'd1, N,Z,N,N);
    tv[25] = mk(N,Z,Z,3'd0, N,Z,3'd0, Y, Y,Y,N,Z,Z,3'd0, N,Z,N,N);

    set_st(N, Z, Z, 3'd0);
    set_ld(N, Z, 3'd0);
    bus.dm_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_dm_write", 32'(bus.dm_write), 32'd0);
    chk("rst_dm_addr", bus.dm_addr, Z);
    chk("rst_dm_wdata", bus.dm_wdata, Z);
    chk("rst_dm_funct3", 32'(bus.dm_funct3), 32'd0);
    chk("rst_ld_hit", 32'(bus.ld_hit), 32'd0);
    chk("rst_ld_stall", 32'(bus.ld_stall), 32'd0);
    chk("rst_ld_fwd", bus.ld_fwd_data, Z);
    tick;

    for (int i = 0; i < NV; i++) begin
      set_st(tv[i].sv, tv[i].sa, tv[i].sd, tv[i].sf);
      set_ld(tv[i].lv, tv[i].la, tv[i].lf);
      bus.dm_ready = tv[i].dr;
      #1;
      chk($sformatf("v%0d_st_ready", i), 32'(bus.st_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(tv[i].emp));
      chk($sformatf("v%0d_dm_write", i), 32'(bus.dm_write), 32'(tv[i].dw));
      chk($sformatf("v%0d_dm_addr", i), bus.dm_addr, tv[i].da);
      chk($sformatf("v%0d_dm_wdata", i), bus.dm_wdata, tv[i].dd);
      chk($sformatf("v%0d_dm_funct3", i), 32'(bus.dm_funct3), 32'(tv[i].df));
      chk($sformatf("v%0d_ld_hit", i), 32'(bus.ld_hit), FWD ? 32'(tv[i].hit) : 32'd0);
      chk($sformatf("v%0d_ld_fwd", i), bus.ld_fwd_data, FWD ? tv[i].fwd : Z);
      chk($sformatf("v%0d_ld_stall", i), 32'(bus.ld_stall), FWD ? 32'(tv[i].stl) : 32'(tv[i].ovl));
      tick;
    end
    set_st(N, Z, Z, 3'd0);
    set_ld(N, Z, 3'd0);

    // Fill to full, hold a fifth store, then drain in order
    bus.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_st(Y, 32'(32'h600 + 4*i), 32'(32'h11 * (i+1)), 3'd2);
      #1 chk($sformatf("t2_ready_push%0d", i), 32'(bus.st_ready), 32'd1);
      tick;
    end
    set_st(Y, 32'h700, 32'h77, 3'd2);
    #1 chk("t2_full_ready", 32'(bus.st_ready), 32'd0);
    tick;
    #1 chk("t2_held_ready", 32'(bus.st_ready), 32'd0);
    chk("t2_head_addr", bus.dm_addr, 32'h600);
    bus.dm_ready = 1'b1;
    #1 chk("t2_drain0_write", 32'(bus.dm_write), 32'd1);
    chk("t2_full_drain_ready", 32'(bus.st_ready), 32'd0);
    chk("t2_drain0_data", bus.dm_wdata, 32'h11);
    tick;
    #1 chk("t2_ready_after_drain", 32'(bus.st_ready), 32'd1);
    chk("t2_drain1_addr", bus.dm_addr, 32'h604);
    chk("t2_drain1_data", bus.dm_wdata, 32'h22);
    tick;
    set_st(N, Z, Z, 3'd0);
    #1 chk("t2_drain2_addr", bus.dm_addr, 32'h608);
    chk("t2_drain2_ready", 32'(bus.st_ready), 32'd1);
    tick;
    #1 chk("t2_drain3_addr", bus.dm_addr, 32'h60C);
    chk("t2_drain3_data", bus.dm_wdata, 32'h44);
    tick;
    #1 chk("t2_drain4_addr", bus.dm_addr, 32'h700);
    chk("t2_drain4_data", bus.dm_wdata, 32'h77);
    tick;
    #1 chk("t2_final_empty", 32'(bus.empty), 32'd1);
    chk("t2_final_write", 32'(bus.dm_write), 32'd0);

    // Partial overlap stalls until the entry drains
    bus.dm_ready = 1'b0;
    set_st(Y, 32'h300, 32'h12, 3'd0);
    tick;
    set_st(N, Z, Z, 3'd0);
    set_ld(Y, 32'h300, 3'd2);
    #1 chk("t4_stall", 32'(bus.ld_stall), 32'd1);
    chk("t4_hit", 32'(bus.ld_hit), 32'd0);
    bus.dm_ready = 1'b1;
    #1 chk("t4_stall_draining", 32'(bus.ld_stall), FWD ? 32'd0 : 32'd1);
    chk("t4_draining_write", 32'(bus.dm_write), 32'd1);
    tick;
    #1 chk("t4_stall_after", 32'(bus.ld_stall), 32'd0);
    chk("t4_empty_after", 32'(bus.empty), 32'd1);
    set_ld(N, Z, 3'd0);

    // Reset in the middle of draining a full queue
    bus.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_st(Y, 32'(32'h800 + 4*i), 32'(32'hA0 + i), 3'd2);
      tick;
    end
    set_st(N, Z, Z, 3'd0);
    bus.dm_ready = 1'b1;
    tick;
    #1 chk("t6_write_before_rst", 32'(bus.dm_write), 32'd1);
    chk("t6_addr_before_rst", bus.dm_addr, 32'h804);
    rst = 1'b1;
    #1 chk("t6_rst_write", 32'(bus.dm_write), 32'd0);
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_addr", bus.dm_addr, Z);
    chk("t6_rst_ready", 32'(bus.st_ready), 32'd1);
    tick;
    rst = 1'b0;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (bus.dm_write) writes++;
      tick;
    end
    chk("t6_writes_after_rst", 32'(writes), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
